// File: rtl/leaf_user_fifo_bridge_pkg.sv
// Shared defaults and width helpers for the leaf user-side FIFO bridge.
package leaf_user_fifo_bridge_pkg;

  localparam int unsigned PAYLOAD_BITS_DEF = 32;
  localparam int unsigned DEPTH_BITS_DEF   = 4;

  // Occupancy must represent 0..2^depth_bits inclusive.
  function automatic int unsigned level_bits(input int unsigned depth_bits);
    return depth_bits + 1;
  endfunction

endpackage

// File: rtl/leaf_user_fifo_bridge_if.sv
// Bundles the leaf-side vld/ack ports, the operator ap_fifo ports and the level taps.
interface leaf_user_fifo_bridge_if
  import leaf_user_fifo_bridge_pkg::*;
#(
  parameter int unsigned PAYLOAD_BITS = PAYLOAD_BITS_DEF,
  parameter int unsigned DEPTH_BITS   = DEPTH_BITS_DEF
);

  logic [PAYLOAD_BITS-1:0]           rx_din;
  logic                              rx_vld;
  logic                              rx_ack;
  logic [PAYLOAD_BITS-1:0]           op_dout;
  logic                              op_empty_n;
  logic                              op_read;
  logic [PAYLOAD_BITS-1:0]           op_din;
  logic                              op_write;
  logic                              op_full_n;
  logic [PAYLOAD_BITS-1:0]           tx_dout;
  logic                              tx_vld;
  logic                              tx_ack;
  logic [level_bits(DEPTH_BITS)-1:0] rx_level;
  logic [level_bits(DEPTH_BITS)-1:0] tx_level;

  modport master (
    output rx_din, rx_vld, op_read, op_din, op_write, tx_ack,
    input  rx_ack, op_dout, op_empty_n, op_full_n, tx_dout, tx_vld, rx_level, tx_level
  );

  modport slave (
    input  rx_din, rx_vld, op_read, op_din, op_write, tx_ack,
    output rx_ack, op_dout, op_empty_n, op_full_n, tx_dout, tx_vld, rx_level, tx_level
  );

endinterface

// File: rtl/leaf_user_fifo_bridge_fifo.sv
// FWFT FIFO with registered, run-gated full_n; ready flags never depend on push/pop.
module bridge_fifo
  import leaf_user_fifo_bridge_pkg::*;
#(
  parameter int unsigned W  = PAYLOAD_BITS_DEF,
  parameter int unsigned DB = DEPTH_BITS_DEF
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      run,
  input  logic                      push,
  input  logic [W-1:0]              din,
  output logic                      full_n,
  input  logic                      pop,
  output logic [W-1:0]              dout,
  output logic                      empty_n,
  output logic [level_bits(DB)-1:0] level
);

  localparam int unsigned      LW       = level_bits(DB);
  localparam logic [LW-1:0]    FULL_LVL = LW'(2 ** DB);

  logic [W-1:0]  mem_q [2 ** DB];
  logic [DB-1:0] wr_ptr_q, wr_ptr_d;
  logic [DB-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic          push_ok, pop_ok;

  always_comb begin
    full_n   = run & (level_q < FULL_LVL);
    empty_n  = (level_q != '0);
    push_ok  = push & full_n;
    pop_ok   = pop & empty_n;
    wr_ptr_d = wr_ptr_q + DB'(push_ok);
    rd_ptr_d = rd_ptr_q + DB'(pop_ok);
    level_d  = level_q + LW'(push_ok) - LW'(pop_ok);
    dout     = mem_q[rd_ptr_q];
    level    = level_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage is left unreset; contents are only visible while level is non-zero.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/leaf_user_fifo_bridge.sv
// Elastic RX/TX buffering between the leaf interface vld/ack ports and an ap_fifo operator.
module leaf_user_fifo_bridge
  import leaf_user_fifo_bridge_pkg::*;
#(
  parameter int unsigned PAYLOAD_BITS = PAYLOAD_BITS_DEF,
  parameter int unsigned DEPTH_BITS   = DEPTH_BITS_DEF
) (
  input  logic                    clk,
  input  logic                    reset,
  leaf_user_fifo_bridge_if.slave  bus
);

  logic run_q, run_d;

  // Holds both accept flags low until one clean edge after reset release.
  always_comb run_d = 1'b1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) run_q <= 1'b0;
    else        run_q <= run_d;
  end

  bridge_fifo #(
    .W  (PAYLOAD_BITS),
    .DB (DEPTH_BITS)
  ) u_rx_fifo (
    .clk     (clk),
    .rst_n   (reset),
    .run     (run_q),
    .push    (bus.rx_vld),
    .din     (bus.rx_din),
    .full_n  (bus.rx_ack),
    .pop     (bus.op_read),
    .dout    (bus.op_dout),
    .empty_n (bus.op_empty_n),
    .level   (bus.rx_level)
  );

  bridge_fifo #(
    .W  (PAYLOAD_BITS),
    .DB (DEPTH_BITS)
  ) u_tx_fifo (
    .clk     (clk),
    .rst_n   (reset),
    .run     (run_q),
    .push    (bus.op_write),
    .din     (bus.op_din),
    .full_n  (bus.op_full_n),
    .pop     (bus.tx_ack),
    .dout    (bus.tx_dout),
    .empty_n (bus.tx_vld),
    .level   (bus.tx_level)
  );

endmodule

// File: tb/tb_leaf_user_fifo_bridge.sv
// Directed bench for leaf_user_fifo_bridge: reset, fill, stream with stalls, wrap, flush.
module tb_leaf_user_fifo_bridge;

  logic clk;
  logic reset;
  int unsigned n_checks;
  int unsigned n_fail;

  leaf_user_fifo_bridge_if #(.PAYLOAD_BITS(32), .DEPTH_BITS(4)) bus ();

  leaf_user_fifo_bridge #(.PAYLOAD_BITS(32), .DEPTH_BITS(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int cyc;
    int w;
    int r;
    int lvl;
    logic wacc;
    logic racc;

    n_checks = 0;
    n_fail   = 0;
    reset        = 1'b0;
    bus.rx_din   = 32'h55;
    bus.rx_vld   = 1'b1;
    bus.op_read  = 1'b0;
    bus.op_din   = '0;
    bus.op_write = 1'b0;
    bus.tx_ack   = 1'b0;

    // Reset hold and release
    repeat (3) tick();
    chk("rst_rx_ack",     32'(bus.rx_ack),     32'd0);
    chk("rst_op_full_n",  32'(bus.op_full_n),  32'd0);
    chk("rst_op_empty_n", 32'(bus.op_empty_n), 32'd0);
    chk("rst_tx_vld",     32'(bus.tx_vld),     32'd0);
    chk("rst_rx_level",   32'(bus.rx_level),   32'd0);
    chk("rst_tx_level",   32'(bus.tx_level),   32'd0);
    reset = 1'b1;
    #1;
    chk("rel_rx_ack_pre",    32'(bus.rx_ack),    32'd0);
    chk("rel_op_full_n_pre", 32'(bus.op_full_n), 32'd0);
    tick();
    chk("rel_rx_ack",    32'(bus.rx_ack),    32'd1);
    chk("rel_op_full_n", 32'(bus.op_full_n), 32'd1);
    chk("rel_rx_level",  32'(bus.rx_level),  32'd0);
    chk("rel_tx_level",  32'(bus.tx_level),  32'd0);
    bus.rx_vld = 1'b0;

    // RX fill to full
    for (int i = 0; i < 16; i++) begin
      bus.rx_vld = 1'b1;
      bus.rx_din = 32'h100 + 32'(i);
      tick();
      if (i == 0) begin
        chk("rx_lat_empty_n", 32'(bus.op_empty_n), 32'd1);
        chk("rx_lat_dout",    bus.op_dout,         32'h100);
      end
    end
    chk("rx_full_level", 32'(bus.rx_level), 32'd16);
    chk("rx_full_ack",   32'(bus.rx_ack),   32'd0);
    bus.rx_din = 32'h1FF;
    tick();
    chk("rx_over_level", 32'(bus.rx_level), 32'd16);
    chk("rx_full_head",  bus.op_dout,       32'h100);
    bus.op_read = 1'b1;
    tick();
    chk("rx_nobypass_level", 32'(bus.rx_level), 32'd15);
    chk("rx_ack_return",     32'(bus.rx_ack),   32'd1);
    chk("rx_head_after_pop", bus.op_dout,       32'h101);
    bus.rx_vld  = 1'b0;
    bus.op_read = 1'b0;

    // Drain to level 5, checking order
    for (int i = 0; i < 10; i++) begin
      chk("rx_drain_dout", bus.op_dout, 32'h101 + 32'(i));
      bus.op_read = 1'b1;
      tick();
    end
    bus.op_read = 1'b0;
    chk("rx_lvl5", 32'(bus.rx_level), 32'd5);

    // Concurrent push/pop at level 5 across the pointer wrap
    for (int i = 0; i < 10; i++) begin
      bus.rx_vld  = 1'b1;
      bus.rx_din  = 32'h200 + 32'(i);
      bus.op_read = 1'b1;
      chk("rx_conc_dout", bus.op_dout, (i < 5) ? 32'h10B + 32'(i) : 32'h200 + 32'(i - 5));
      tick();
      chk("rx_conc_level", 32'(bus.rx_level), 32'd5);
    end
    bus.rx_vld = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("rx_tail_dout", bus.op_dout, 32'h205 + 32'(i));
      tick();
    end
    chk("rx_empty_n", 32'(bus.op_empty_n), 32'd0);
    tick();
    chk("rx_read_empty_level", 32'(bus.rx_level),   32'd0);
    chk("rx_read_empty_n",     32'(bus.op_empty_n), 32'd0);
    bus.op_read = 1'b0;

    // TX: fill with ack low, then stream with ack toggling
    cyc = 0; w = 0; r = 0; lvl = 0;
    while (r < 20 && cyc < 200) begin
      bus.op_write = (w < 20);
      bus.op_din   = 32'hA0 + 32'(w);
      bus.tx_ack   = (cyc >= 17) && ((cyc % 2) == 1);
      chk("tx_vld",     32'(bus.tx_vld),    (lvl != 0) ? 32'd1 : 32'd0);
      chk("tx_full_n",  32'(bus.op_full_n), (lvl < 16) ? 32'd1 : 32'd0);
      chk("tx_level",   32'(bus.tx_level),  32'(lvl));
      if (lvl != 0) chk("tx_dout", bus.tx_dout, 32'hA0 + 32'(r));
      wacc = bus.op_write && (lvl < 16);
      racc = bus.tx_ack && (lvl != 0);
      if (wacc) w++;
      if (racc) r++;
      lvl = lvl + (wacc ? 1 : 0) - (racc ? 1 : 0);
      tick();
      cyc++;
    end
    bus.op_write = 1'b0;
    bus.tx_ack   = 1'b0;
    chk("tx_all_drained", 32'(r), 32'd20);
    chk("tx_end_level",   32'(bus.tx_level), 32'd0);
    chk("tx_end_vld",     32'(bus.tx_vld),   32'd0);

    // Mid-stream reset flushes both paths asynchronously
    for (int i = 0; i < 7; i++) begin
      bus.op_write = 1'b1;
      bus.op_din   = 32'hC0 + 32'(i);
      bus.rx_vld   = (i < 3);
      bus.rx_din   = 32'h300 + 32'(i);
      tick();
    end
    bus.op_write = 1'b0;
    bus.rx_vld   = 1'b0;
    chk("pre_flush_tx_level", 32'(bus.tx_level), 32'd7);
    chk("pre_flush_rx_level", 32'(bus.rx_level), 32'd3);
    chk("pre_flush_tx_dout",  bus.tx_dout,       32'hC0);
    reset = 1'b0;
    #1;
    chk("flush_tx_vld_async", 32'(bus.tx_vld),     32'd0);
    chk("flush_tx_level",     32'(bus.tx_level),   32'd0);
    chk("flush_rx_level",     32'(bus.rx_level),   32'd0);
    chk("flush_op_empty_n",   32'(bus.op_empty_n), 32'd0);
    tick();
    reset = 1'b1;
    tick();
    tick();
    chk("post_flush_tx_vld",    32'(bus.tx_vld),    32'd0);
    chk("post_flush_op_full_n", 32'(bus.op_full_n), 32'd1);
    bus.op_write = 1'b1;
    bus.op_din   = 32'h77;
    tick();
    bus.op_write = 1'b0;
    chk("new_tx_vld",  32'(bus.tx_vld),   32'd1);
    chk("new_tx_dout", bus.tx_dout,       32'h77);
    chk("new_tx_lvl",  32'(bus.tx_level), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/leaf_user_fifo_bridge.md
Name: leaf_user_fifo_bridge

Overview:
- Elastic buffer between the leaf interface's user-side vld/ack ports and an HLS operator using ap_fifo-style ports (empty_n/read, full_n/write).
- RX path: interface-to-user words are buffered and presented to the operator as a first-word-fall-through (FWFT) FIFO read port.
- TX path: operator writes are buffered and drained into the interface's user-to-interface vld/ack input.
- Decouples operator stalls from the leaf interface so back-pressure never creates combinational loops across the boundary.

Parameters:
- PAYLOAD_BITS, 32, word width on both paths.
- DEPTH_BITS, 4, log2 of each FIFO depth (16 entries).

Ports:
- clk  in  1  single clock for all logic.
- reset  in  1  asynchronous, active-low reset.
- rx_din  in  PAYLOAD_BITS  word from the leaf interface (dout_leaf_interface2user).
- rx_vld  in  1  word valid from the leaf interface (vld_interface2user).
- rx_ack  out  1  accept to the leaf interface (ack_user2interface).
- op_dout  out  PAYLOAD_BITS  head word of the RX FIFO to the operator.
- op_empty_n  out  1  RX FIFO non-empty.
- op_read  in  1  operator pops the RX head.
- op_din  in  PAYLOAD_BITS  word from the operator.
- op_write  in  1  operator pushes op_din.
- op_full_n  out  1  TX FIFO not full.
- tx_dout  out  PAYLOAD_BITS  word to the leaf interface (din_leaf_user2interface).
- tx_vld  out  1  word valid to the leaf interface (vld_user2interface).
- tx_ack  in  1  accept from the leaf interface (ack_interface2user).
- rx_level  out  DEPTH_BITS+1  RX FIFO occupancy.
- tx_level  out  DEPTH_BITS+1  TX FIFO occupancy.

Behaviour:
- Transfer rule, both vld/ack boundaries: a word moves on a rising clk edge where vld and ack are both 1. vld must hold and data must stay stable until accepted.
- Reset (reset=0, async):
  - pointers and levels go to 0.
  - rx_ack=0, op_empty_n=0, op_full_n=0, tx_vld=0; op_dout and tx_dout are don't-care.
  - A run flop sets on the first clk edge after reset deasserts. rx_ack and op_full_n stay 0 until run=1.
- rx_ack = run & (rx_level < 2^DEPTH_BITS).
  - Registered state only; no dependence on rx_vld.
  - When full, rx_ack is 0 even if op_read pops in the same cycle. The freed slot is advertised on the next cycle (no bypass).
- op_full_n = run & (tx_level < 2^DEPTH_BITS). Same no-bypass rule applies.
- op_read while op_empty_n=0 and op_write while op_full_n=0 are ignored (no pointer or level change).
- FWFT read port:
  - op_empty_n = (level != 0) and op_dout = mem[rd_ptr].
  - A word pushed into an empty FIFO appears on op_dout/op_empty_n one cycle later. Latency in→out = 1 cycle on each path.
- tx_vld = (tx_level != 0), tx_dout = head of the TX FIFO.
- Simultaneous push and pop in one cycle on a non-empty, non-full FIFO: level unchanged, both pointers advance.
- Pointers are DEPTH_BITS wide and wrap modulo 2^DEPTH_BITS. Level is DEPTH_BITS+1 wide, range 0..2^DEPTH_BITS.
- Word order is preserved on each path. No word is ever dropped or duplicated.
- Reset asserted mid-operation flushes both FIFOs immediately. Buffered words are lost; this is by design.
- RX and TX paths are fully independent.

Decomposition:
- Shared package: PAYLOAD_BITS/DEPTH_BITS defaults and the level width function (DEPTH_BITS+1).
- Sub-module bridge_fifo:
  - Ports: push/din/full_n, pop/dout/empty_n, level; run-gated full_n.
  - Instantiated twice, once for RX and once for TX.
  - Top-level only maps vld/ack ↔ push/full_n and empty_n ↔ vld.

Test Plan:
- Reset release: hold reset=0 for 3 cycles, rx_vld=1 → rx_ack=0 and op_full_n=0 during reset and on the first post-release edge. rx_ack=1 and op_full_n=1 from the second cycle; levels 0.
- RX fill to full: rx_vld=1 with data 0x100..0x10F, op_read=0 → 16 accepts, rx_level=16, rx_ack=0. Then op_read=1 for one cycle → op_dout=0x100 popped, rx_ack returns to 1 the following cycle. rx_level never exceeds 16.
- TX stream with stall: 20 op_writes of 0xA0..0xB3, tx_ack toggling 1,0,1,0 → tx_dout order exactly 0xA0..0xB3. op_full_n drops when tx_level=16. tx_dout is stable while tx_vld=1 and tx_ack=0.
- Concurrent push/pop at level 5: rx_vld=1, op_read=1 for 10 cycles → rx_level stays 5 and order is preserved. Pointers wrap past 15 with no corruption.
- Illegal ops: op_read on empty, op_write on full → levels and outputs unchanged, no duplicated or lost words.
- Mid-stream reset: reset=0 at tx_level=7 → tx_vld=0 asynchronously (before the next clk edge), levels 0. After release, tx_vld stays 0 until a new op_write.
